// File: rtl/tsr_argmax_pkg.sv
// Shared types and compare helper for the streaming argmax block.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package tsr_argmax_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Scores are widened to this width before comparing so one helper fits any DATA_W
    localparam int EXT_W = 64;

    // True when candidate b (higher class index) displaces candidate a.
    // tie_first=0 lets the higher index take ties, tie_first=1 keeps the lower one.
    function automatic logic b_beats_a(input logic [EXT_W-1:0] a,
                                       input logic [EXT_W-1:0] b,
                                       input logic             sgn,
                                       input logic             tie_first);
        logic gt;
        if (sgn) gt = $signed(b) > $signed(a);
        else     gt = b > a;
        return tie_first ? gt : (gt | (a == b));
    endfunction

endpackage

// File: rtl/argmax_node.sv
// Registered compare-select cell: keeps the winner of a (lower index) and b (higher index), optional runner-up when ARGMAX_MARGIN_EN is defined.
// Latency: 1 cycle when i_en; i_clr empties the cell synchronously.
// Backpressure: none; the cell loads whenever enabled.
module argmax_node
    import tsr_argmax_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int IDX_W       = 6,
    parameter int SIGNED_MODE = 0,
    parameter int TIE_FIRST   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_a_vld,
    input  logic [IDX_W-1:0]  i_a_idx,
    input  logic [DATA_W-1:0] i_a_val,
    input  logic              i_b_vld,
    input  logic [IDX_W-1:0]  i_b_idx,
    input  logic [DATA_W-1:0] i_b_val,
`ifdef ARGMAX_MARGIN_EN
    input  logic [DATA_W-1:0] i_a_sec,
    input  logic [DATA_W-1:0] i_b_sec,
`endif
    output logic              o_vld,
    output logic [IDX_W-1:0]  o_idx,
    output logic [DATA_W-1:0] o_val
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W-1:0] o_sec
`endif
);

    localparam logic [DATA_W-1:0] MIN_VAL = (SIGNED_MODE != 0) ?
        {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};

    function automatic logic [EXT_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED_MODE != 0) return {{(EXT_W-DATA_W){v[DATA_W-1]}}, v};
        return {{(EXT_W-DATA_W){1'b0}}, v};
    endfunction

    logic              r_vld;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_val;
    logic              w_b_win;

    // An empty a always yields to b; an empty b never wins
    assign w_b_win = !i_a_vld |
                     (i_b_vld & b_beats_a(ext(i_a_val), ext(i_b_val),
                                          SIGNED_MODE != 0, TIE_FIRST != 0));

`ifdef ARGMAX_MARGIN_EN
    logic [DATA_W-1:0] r_sec;
    logic [DATA_W-1:0] w_lose;
    logic [DATA_W-1:0] w_as;
    logic [DATA_W-1:0] w_bs;
    logic [DATA_W-1:0] w_s1;
    logic [DATA_W-1:0] w_sec;

    // Runner-up is the largest of the loser and both incoming runner-ups; empty inputs count as MIN
    always_comb begin
        w_as   = i_a_vld ? i_a_sec : MIN_VAL;
        w_bs   = i_b_vld ? i_b_sec : MIN_VAL;
        w_lose = w_b_win ? (i_a_vld ? i_a_val : MIN_VAL)
                         : (i_b_vld ? i_b_val : MIN_VAL);
        w_s1   = b_beats_a(ext(w_as), ext(w_bs), SIGNED_MODE != 0, 1'b0) ? w_bs : w_as;
        w_sec  = b_beats_a(ext(w_s1), ext(w_lose), SIGNED_MODE != 0, 1'b0) ? w_lose : w_s1;
    end

    // Runner-up register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_sec <= '0;
        else if (i_clr) r_sec <= '0;
        else if (i_en)  r_sec <= w_sec;
    end

    assign o_sec = r_sec;
`endif

    // Winner register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_idx <= '0;
            r_val <= '0;
        end else if (i_clr) begin
            r_vld <= 1'b0;
            r_idx <= '0;
            r_val <= '0;
        end else if (i_en) begin
            r_vld <= i_a_vld | i_b_vld;
            r_idx <= w_b_win ? i_b_idx : i_a_idx;
            r_val <= w_b_win ? i_b_val : i_a_val;
        end
    end

    assign o_vld = r_vld;
    assign o_idx = r_idx;
    assign o_val = r_val;

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over a frame of class scores; ARGMAX_MARGIN_EN adds the best-minus-runner-up output.
// Latency: result valid clog2(LANES)+2 cycles after the edge accepting i_last (tree depth min 1).
// Backpressure: i_ready low outside ACCUM; result held until o_ready; compare pipeline never stalls.
module argmax_stream
    import tsr_argmax_pkg::*;
#(
    parameter  int LANES       = 4,
    parameter  int DATA_W      = 8,
    parameter  int NUM_CLASS   = 43,
    parameter  int SIGNED_MODE = 0,
    parameter  int TIE_FIRST   = 0,
    localparam int IDX_W       = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [LANES*DATA_W-1:0] i_data,
    input  logic                    i_last,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [IDX_W-1:0]        max_idx,
    output logic [DATA_W-1:0]       max_val,
    output logic                    o_len_err
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W-1:0]       o_margin
`endif
);

    localparam int BEATS = (NUM_CLASS + LANES - 1) / LANES;
    localparam int STG   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int P     = 1 << STG;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [DATA_W-1:0] MIN_VAL = (SIGNED_MODE != 0) ?
        {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};

    state_t                  r_state;
    state_t                  w_state_nx;
    logic                    r_up;
    logic                    w_acc;
    logic                    w_flush_done;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err_pend;

    logic                    r_cap_vld;
    logic                    r_cap_last;
    logic [LANES*DATA_W-1:0] r_cap_dat;
    logic [CNT_W-1:0]        r_cap_beat;
    logic [STG:1]            r_pv;
    logic [STG:1]            r_pl;
    logic                    r_acc_last;

    logic                    w_vld [0:STG][0:P-1];
    logic [IDX_W-1:0]        w_idx [0:STG][0:P-1];
    logic [DATA_W-1:0]       w_val [0:STG][0:P-1];
    logic                    w_acc_vld;
    logic [IDX_W-1:0]        w_acc_idx;
    logic [DATA_W-1:0]       w_acc_val;

    logic [IDX_W-1:0]        r_max_idx;
    logic [DATA_W-1:0]       r_max_val;
    logic                    r_len_err;

`ifdef ARGMAX_MARGIN_EN
    logic [DATA_W-1:0]       w_sec [0:STG][0:P-1];
    logic [DATA_W-1:0]       w_acc_sec;
    logic [DATA_W-1:0]       r_margin;
    assign o_margin = r_margin;
`endif

    assign i_ready      = r_up & (r_state == ST_ACCUM);
    assign o_valid      = (r_state == ST_HOLD);
    assign w_acc        = i_valid & i_ready;
    assign w_flush_done = (r_state == ST_FLUSH) & r_acc_last;

    // State register; r_up keeps i_ready low until the first edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_up    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_up    <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_ACCUM: if (w_acc & i_last) w_state_nx = ST_FLUSH;
            ST_FLUSH: if (r_acc_last)     w_state_nx = ST_HOLD;
            ST_HOLD:  if (o_ready)        w_state_nx = ST_ACCUM;
            default:                      w_state_nx = ST_ACCUM;
        endcase
    end

    // Saturating beat counter and frame-length check latched with i_last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
        end else begin
            if (w_flush_done)
                r_cnt <= '0;
            else if (w_acc && (r_cnt != CNT_W'(BEATS)))
                r_cnt <= r_cnt + 1'b1;
            if (w_acc & i_last)
                r_err_pend <= (r_cnt != CNT_W'(BEATS - 1));
        end
    end

    // Capture register; the beat number travels with the data to derive class indices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld  <= 1'b0;
            r_cap_last <= 1'b0;
            r_cap_dat  <= '0;
            r_cap_beat <= '0;
        end else begin
            r_cap_vld <= w_acc;
            if (w_acc) begin
                r_cap_last <= i_last;
                r_cap_dat  <= i_data;
                r_cap_beat <= r_cnt;
            end
        end
    end

    // Valid/last flags shadowing the tree stages, plus the flag marking the final beat in the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv       <= '0;
            r_pl       <= '0;
            r_acc_last <= 1'b0;
        end else begin
            r_pv[1] <= r_cap_vld;
            r_pl[1] <= r_cap_vld & r_cap_last;
            for (int s = 2; s <= STG; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pl[s] <= r_pl[s-1];
            end
            r_acc_last <= r_pv[STG] & r_pl[STG];
        end
    end

    // Tree leaves: lanes past NUM_CLASS (including a whole saturated beat) enter empty
    genvar gl, gn;
    for (gn = 0; gn < P; gn++) begin : g_in
        if (gn < LANES) begin : g_lane
            int w_cls;
            assign w_cls           = int'(r_cap_beat) * LANES + gn;
            assign w_vld[0][gn]    = (w_cls < NUM_CLASS);
            assign w_idx[0][gn]    = w_cls[IDX_W-1:0];
            assign w_val[0][gn]    = r_cap_dat[gn*DATA_W +: DATA_W];
        end else begin : g_pad
            assign w_vld[0][gn]    = 1'b0;
            assign w_idx[0][gn]    = '0;
            assign w_val[0][gn]    = '0;
        end
`ifdef ARGMAX_MARGIN_EN
        assign w_sec[0][gn] = MIN_VAL;
`endif
    end

    // Binary compare tree, one registered level per stage
    for (gl = 0; gl < STG; gl++) begin : g_lvl
        for (gn = 0; gn < P; gn++) begin : g_node
            if (gn < (P >> (gl + 1))) begin : g_cell
                argmax_node #(
                    .DATA_W(DATA_W), .IDX_W(IDX_W),
                    .SIGNED_MODE(SIGNED_MODE), .TIE_FIRST(TIE_FIRST)
                ) u_node (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .i_en    (1'b1),
                    .i_clr   (1'b0),
                    .i_a_vld (w_vld[gl][2*gn]),
                    .i_a_idx (w_idx[gl][2*gn]),
                    .i_a_val (w_val[gl][2*gn]),
                    .i_b_vld (w_vld[gl][2*gn+1]),
                    .i_b_idx (w_idx[gl][2*gn+1]),
                    .i_b_val (w_val[gl][2*gn+1]),
`ifdef ARGMAX_MARGIN_EN
                    .i_a_sec (w_sec[gl][2*gn]),
                    .i_b_sec (w_sec[gl][2*gn+1]),
                    .o_sec   (w_sec[gl+1][gn]),
`endif
                    .o_vld   (w_vld[gl+1][gn]),
                    .o_idx   (w_idx[gl+1][gn]),
                    .o_val   (w_val[gl+1][gn])
                );
            end else begin : g_tie
                assign w_vld[gl+1][gn] = 1'b0;
                assign w_idx[gl+1][gn] = '0;
                assign w_val[gl+1][gn] = '0;
`ifdef ARGMAX_MARGIN_EN
                assign w_sec[gl+1][gn] = MIN_VAL;
`endif
            end
        end
    end

    // Running best: earlier beats are side a, so the tie rule carries across beats unchanged
    argmax_node #(
        .DATA_W(DATA_W), .IDX_W(IDX_W),
        .SIGNED_MODE(SIGNED_MODE), .TIE_FIRST(TIE_FIRST)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (r_pv[STG]),
        .i_clr   (w_flush_done),
        .i_a_vld (w_acc_vld),
        .i_a_idx (w_acc_idx),
        .i_a_val (w_acc_val),
        .i_b_vld (w_vld[STG][0]),
        .i_b_idx (w_idx[STG][0]),
        .i_b_val (w_val[STG][0]),
`ifdef ARGMAX_MARGIN_EN
        .i_a_sec (w_acc_sec),
        .i_b_sec (w_sec[STG][0]),
        .o_sec   (w_acc_sec),
`endif
        .o_vld   (w_acc_vld),
        .o_idx   (w_acc_idx),
        .o_val   (w_acc_val)
    );

    // Result registers load once per frame and hold through backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_idx <= '0;
            r_max_val <= '0;
            r_len_err <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            r_margin  <= '0;
`endif
        end else if (w_flush_done) begin
            r_max_idx <= w_acc_idx;
            r_max_val <= w_acc_val;
            r_len_err <= r_err_pend;
`ifdef ARGMAX_MARGIN_EN
            r_margin  <= w_acc_val - w_acc_sec;
`endif
        end
    end

    assign max_idx   = r_max_idx;
    assign max_val   = r_max_val;
    assign o_len_err = r_len_err;

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: two instances (unsigned/tie-high and signed/tie-low) share one stimulus stream.
// Latency: expects the result 4 cycles after the i_last edge.
// Backpressure: exercises a 20-cycle o_ready stall and a mid-frame reset.
module tb_argmax_stream;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_last;
    logic        o_ready;

    logic        rdy0, vld0, err0;
    logic [5:0]  idx0;
    logic [7:0]  val0;
    logic        rdy1, vld1, err1;
    logic [5:0]  idx1;
    logic [7:0]  val1;
`ifdef ARGMAX_MARGIN_EN
    logic [7:0]  mar0, mar1;
`endif

    argmax_stream #(.LANES(4), .DATA_W(8), .NUM_CLASS(43), .SIGNED_MODE(0), .TIE_FIRST(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(rdy0), .i_data(i_data),
        .i_last(i_last), .o_valid(vld0), .o_ready(o_ready), .max_idx(idx0), .max_val(val0),
`ifdef ARGMAX_MARGIN_EN
        .o_margin(mar0),
`endif
        .o_len_err(err0)
    );

    argmax_stream #(.LANES(4), .DATA_W(8), .NUM_CLASS(43), .SIGNED_MODE(1), .TIE_FIRST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(rdy1), .i_data(i_data),
        .i_last(i_last), .o_valid(vld1), .o_ready(o_ready), .max_idx(idx1), .max_val(val1),
`ifdef ARGMAX_MARGIN_EN
        .o_margin(mar1),
`endif
        .o_len_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int base; int ha; int va; int hb; int vb; int nb;
        int e0_idx; int e0_val; int e1_idx; int e1_val; int e_err; int m0; int m1;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] sc [0:47];
    int         n_chk;
    int         n_pass;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic build(input int v);
        for (int i = 0; i < 48; i++) sc[i] = 8'(tbl[v].base);
        if (tbl[v].ha >= 0) sc[tbl[v].ha] = 8'(tbl[v].va);
        if (tbl[v].hb >= 0) sc[tbl[v].hb] = 8'(tbl[v].vb);
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!rdy0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_frame", int'(rdy0 & rdy1), 1);
    endtask

    task automatic send(input int nb, input bit with_last);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 4; k++) i_data[k*8 +: 8] = sc[b*4 + k];
            i_last  = with_last && (b == nb - 1);
            i_valid = 1'b1;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic run_vec(input int v, input int hold);
        int         n;
        int         bad;
        logic [5:0] s_idx;
        logic [7:0] s_val;
        wait_rdy();
        build(v);
        send(tbl[v].nb, 1'b1);
        n = 0;
        while (!vld0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 4);
        chk("valid_signed_inst", int'(vld1), 1);
        chk("idx_unsigned_tiehigh", int'(idx0), tbl[v].e0_idx);
        chk("val_unsigned_tiehigh", int'(val0), tbl[v].e0_val);
        chk("idx_signed_tielow", int'(idx1), tbl[v].e1_idx);
        chk("val_signed_tielow", int'(val1), tbl[v].e1_val);
        chk("len_err0", int'(err0), tbl[v].e_err);
        chk("len_err1", int'(err1), tbl[v].e_err);
`ifdef ARGMAX_MARGIN_EN
        chk("margin0", int'(mar0), tbl[v].m0);
        chk("margin1", int'(mar1), tbl[v].m1);
`endif
        if (hold > 0) begin
            bad   = 0;
            s_idx = idx0;
            s_val = val0;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                if (idx0 != s_idx || val0 != s_val || !vld0 || rdy0 || rdy1 ||
                    int'(err0) != tbl[v].e_err)
                    bad++;
            end
            chk("hold_stable", bad, 0);
        end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        chk("ready_after_handshake", int'(rdy0), 1);
        chk("valid_after_handshake", int'(vld0), 0);
    endtask

    initial begin
        int bad;
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        o_ready = 1'b0;

        //            base ha  va   hb  vb  nb  e0i e0v  e1i e1v err m0   m1
        tbl[0] = '{10,  17, 200, -1, 0,   11, 17, 200, 0,  10,  0, 190, 0};
        tbl[1] = '{0,   5,  99,  30, 99,  11, 30, 99,  5,  99,  0, 0,   0};
        tbl[2] = '{0,   2,  127, 3,  128, 11, 3,  128, 2,  127, 0, 1,   127};
        tbl[3] = '{0,   42, 1,   43, 255, 11, 42, 1,   42, 1,   0, 1,   1};
        tbl[4] = '{0,   7,  50,  -1, 0,   5,  7,  50,  7,  50,  1, 50,  50};
        tbl[5] = '{3,   45, 250, -1, 0,   12, 42, 3,   0,  3,   1, 0,   0};
        tbl[6] = '{200, 0,  201, -1, 0,   11, 0,  201, 0,  201, 0, 1,   1};

        #12;
        chk("reset_i_ready", int'(rdy0), 0);
        chk("reset_o_valid", int'(vld0), 0);
        chk("reset_max_idx", int'(idx0), 0);
        chk("reset_max_val", int'(val0), 0);
        chk("reset_len_err", int'(err0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_first_clock", int'(rdy0), 1);

        for (int v = 0; v < 7; v++) run_vec(v, 0);

        // Backpressure stall followed by a fresh frame
        run_vec(0, 20);
        run_vec(1, 0);

        // Reset in the middle of a frame: partial frame must vanish
        wait_rdy();
        build(0);
        send(6, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midreset_i_ready", int'(rdy0), 0);
        chk("midreset_o_valid", int'(vld0), 0);
        chk("midreset_max_idx", int'(idx0), 0);
        chk("midreset_max_val", int'(val0), 0);
        chk("midreset_len_err", int'(err0), 0);
`ifdef ARGMAX_MARGIN_EN
        chk("midreset_margin", int'(mar0), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midreset_ready_rise", int'(rdy0), 1);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (vld0 || vld1) bad++;
        end
        chk("midreset_no_output", bad, 0);
        run_vec(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/argmax_stream.md
ARGMAX_STREAM -- requirements
Module: argmax_stream

Interface
REQ-001 Parameter LANES, default 4: class scores per input beat, >=1.
REQ-002 Parameter DATA_W, default 8: score width in bits.
REQ-003 Parameter NUM_CLASS, default 43: classes per frame, >=1; BEATS = ceil(NUM_CLASS/LANES); IDX_W = max(1, clog2(NUM_CLASS)).
REQ-004 Parameter SIGNED_MODE, default 0: 0 compares scores unsigned, 1 compares them two's-complement.
REQ-005 Parameter TIE_FIRST, default 0: 0 makes the highest index win a tie, 1 makes the lowest index win.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 i_valid  input  1  input beat valid.
REQ-009 i_ready  output  1  block accepts a beat; a beat transfers when i_valid & i_ready.
REQ-010 i_data  input  LANES*DATA_W  lane k in bits [k*DATA_W +: DATA_W]; class index = beat*LANES + k.
REQ-011 i_last  input  1  marks the final beat of a frame.
REQ-012 o_valid  output  1  result valid.
REQ-013 o_ready  input  1  downstream accepts result; handshake when o_valid & o_ready.
REQ-014 max_idx  output  IDX_W  index of the winning class.
REQ-015 max_val  output  DATA_W  score of the winning class.
REQ-016 o_len_err  output  1  frame beat count at i_last differed from BEATS.
REQ-017 o_margin  output  DATA_W  max_val minus runner-up score; present only with ARGMAX_MARGIN_EN.

Function
REQ-018 Accepted beats SHALL pass a capture register, then a clog2(LANES)-stage registered compare tree (1 stage when LANES=1), then a running-best accumulator register.
REQ-019 Lanes whose class index >= NUM_CLASS SHALL never win, whatever their data.
REQ-020 Ties within the tree and across beats SHALL resolve per TIE_FIRST: >= toward the higher index when 0, strict > when 1.
REQ-021 A beat counter SHALL count accepted beats from 0 and saturate at BEATS; beats beyond BEATS are treated as all-padding.
REQ-022 FSM states: ACCUM, FLUSH, HOLD; ACCUM->FLUSH on accepted i_last; FLUSH->HOLD when the last beat leaves the accumulator; HOLD->ACCUM on output handshake.
REQ-023 i_ready SHALL be 1 only in ACCUM; the compare pipeline never stalls.
REQ-024 o_valid SHALL rise exactly clog2(LANES)+2 cycles after the clock edge that accepted i_last, and shall equal (state==HOLD).
REQ-025 max_idx, max_val, o_len_err and o_margin SHALL stay stable while o_valid=1 and o_ready=0.
REQ-026 o_len_err SHALL be 1 iff the beat count including the i_last beat is not equal to BEATS; the result is still produced.
REQ-027 Accepting a new beat in the same cycle as the HOLD->ACCUM handshake SHALL NOT occur, since i_ready is computed from the registered state.
REQ-028 The accumulator and the beat counter SHALL clear on the FLUSH->HOLD transition so that the next frame starts clean.

Reset
REQ-029 While rst_n=0: state=ACCUM, counters, pipeline valids and accumulator cleared, i_ready=0, o_valid=0, and max_idx, max_val, o_len_err, o_margin all 0.
REQ-030 i_ready SHALL rise on the first clock after rst_n deasserts; a partial frame in progress at reset is discarded with no output.

Configuration
REQ-031 With macro ARGMAX_MARGIN_EN defined, every tree node and the accumulator SHALL carry the top-2 scores, and o_margin = best - second; the runner-up initialises to the minimum representable value, so NUM_CLASS=1 gives best - min.
REQ-032 Without ARGMAX_MARGIN_EN, the o_margin port and all top-2 logic SHALL be absent; latency is unchanged.

Structure
REQ-033 Package tsr_argmax_pkg SHALL hold the compare-function helper (signed/unsigned, tie rule) and the state enumeration.
REQ-034 One sub-module, argmax_node, SHALL implement a single registered compare-select cell (optionally top-2); the tree SHALL be generated from it.

Verification (LANES=4, DATA_W=8, NUM_CLASS=43, BEATS=11, latency 4)
REQ-035 Setup: all scores 10, class 17 = 200, 11 beats. Required: max_idx=17, max_val=200, o_margin=190, o_len_err=0, o_valid exactly 4 cycles after the i_last edge.
REQ-036 Setup: classes 5 and 30 = 99, rest 0. Required: max_idx=30 with TIE_FIRST=0, max_idx=5 with TIE_FIRST=1.
REQ-037 Setup: class 2 = 0x7F, class 3 = 0x80, rest 0. Required: max_idx=2 with SIGNED_MODE=1, max_idx=3 with SIGNED_MODE=0.
REQ-038 Setup: class 42 = 1, padding lane (index 43) = 0xFF, rest 0. Required: max_idx=42, max_val=1.
REQ-039 Setup: o_ready held 0 for 20 cycles after o_valid. Required: outputs stable and i_ready=0; after the handshake, i_ready=1 next cycle and the next frame is correct. Separately, i_last on beat 5 gives o_len_err=1.
REQ-040 Setup: rst_n pulsed low after 6 beats of a frame. Required: all outputs 0, no o_valid; a following full frame yields the correct result.
